// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// The instruction format is [20:16] opcode, [15:0] operand.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int unsigned INSTR_WIDTH = 21;
    localparam int unsigned OP_MSB      = 20;
    localparam int unsigned OP_LSB      = 16;

    localparam logic [4:0] OP_JMP = 5'b01001;
    localparam logic [4:0] OP_CAL = 5'b01101;
    localparam logic [4:0] OP_RET = 5'b10001;

    // jmp 0: the safe landing word for anything not loaded
    localparam logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = 21'b010010000000000000000;

    function automatic logic [INSTR_WIDTH-1:0] make_instr(input logic [4:0] op,
                                                          input logic [15:0] operand);
        return {op, operand};
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Simple dual-port synchronous RAM: one write port, one enabled registered read port.
// No reset, so synthesis maps it onto block RAM.
module prog_mem_array #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prog_mem.sv
// Loadable instruction memory: word-serial loader FSM, valid-word counter and
// default-word substitution for fetches outside the loaded program.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int unsigned          ROM_WIDTH     = 21,
    parameter int unsigned          ADDR_WIDTH    = 16,
    parameter int unsigned          DEPTH         = 256,
    parameter logic [ROM_WIDTH-1:0] DEFAULT_INSTR = prog_mem_pkg::DEFAULT_INSTR
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic                  fetch_req,
    output logic [ROM_WIDTH-1:0]  data,
    output logic                  data_valid,
    output logic                  busy,
    input  logic                  load_start,
    input  logic [ROM_WIDTH-1:0]  load_data,
    input  logic                  load_valid,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_ovf
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned CMPW = (ADDR_WIDTH > CW) ? ADDR_WIDTH : CW;

    state_t             state;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      loaded_count;
    logic               fetch_go;
    logic               word_go;
    logic               in_range;
    logic               rd_in_range;
    logic [ROM_WIDTH-1:0] rd_data;

    assign fetch_go = fetch_req && !load_start && (state != LOAD);
    assign word_go  = (state == LOAD) && load_valid && !load_start;
    // Full-width compare: addresses at or beyond DEPTH can never be in range
    assign in_range = CMPW'(ADDR) < CMPW'(loaded_count);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= EMPTY;
            wr_ptr       <= '0;
            loaded_count <= '0;
            load_ovf     <= 1'b0;
            busy         <= 1'b0;
            load_ready   <= 1'b0;
            data_valid   <= 1'b0;
            rd_in_range  <= 1'b0;
        end else begin
            data_valid <= fetch_go;
            if (fetch_go) begin
                rd_in_range <= in_range;
            end
            if (load_start) begin
                state        <= LOAD;
                wr_ptr       <= '0;
                loaded_count <= '0;
                load_ovf     <= 1'b0;
                busy         <= 1'b1;
                load_ready   <= 1'b1;
            end else if (word_go) begin
                wr_ptr       <= wr_ptr + 1'b1;
                loaded_count <= loaded_count + 1'b1;
                if (load_last || (wr_ptr == AW'(DEPTH - 1))) begin
                    state      <= READY;
                    busy       <= 1'b0;
                    load_ready <= 1'b0;
                    load_ovf   <= !load_last;
                end
            end
        end
    end

    prog_mem_array #(
        .WIDTH (ROM_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (CLK),
        .we    (word_go),
        .waddr (wr_ptr),
        .wdata (load_data),
        .re    (fetch_go),
        .raddr (ADDR[AW-1:0]),
        .rdata (rd_data)
    );

    // The held range bit keeps data stable between fetches and forces the default after reset
    assign data = rd_in_range ? rd_data : DEFAULT_INSTR;

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem: two instances (DEPTH 256 and DEPTH 4) share stimulus,
// a program-level model predicts fetch responses and loader status.
module tb_prog_mem;

    localparam logic [20:0] DEF = 21'b010010000000000000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic        fetch_req = 1'b0;
    logic        load_start = 1'b0;
    logic [20:0] load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_last = 1'b0;

    logic [20:0] data_w [2];
    logic        dv_w   [2];
    logic        busy_w [2];
    logic        lr_w   [2];
    logic        ovf_w  [2];

    int vectors = 0;
    int miscompares = 0;

    // Program-level model per instance
    int          depth_m [2] = '{256, 4};
    logic [20:0] m_mem   [2][256];
    int          m_cnt   [2];
    bit          m_loading [2];
    bit          m_ovf   [2];
    logic [20:0] q0 [$];
    logic [20:0] q1 [$];

    always #5 clk = ~clk;

    prog_mem #(.DEPTH(256)) dut (
        .CLK(clk), .RST(rst), .ADDR(addr), .fetch_req(fetch_req),
        .data(data_w[0]), .data_valid(dv_w[0]), .busy(busy_w[0]),
        .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
        .load_last(load_last), .load_ready(lr_w[0]), .load_ovf(ovf_w[0])
    );

    prog_mem #(.DEPTH(4)) dut4 (
        .CLK(clk), .RST(rst), .ADDR(addr), .fetch_req(fetch_req),
        .data(data_w[1]), .data_valid(dv_w[1]), .busy(busy_w[1]),
        .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
        .load_last(load_last), .load_ready(lr_w[1]), .load_ovf(ovf_w[1])
    );

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d actual=%h required=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(input int i, input logic [20:0] v);
        if (i == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic q_pop(input int i, output logic [20:0] v);
        if (i == 0) v = q0.pop_front(); else v = q1.pop_front();
    endtask

    // One clock of stimulus; the model predicts what each instance must do on this edge
    task automatic step(input bit fr, input logic [15:0] a, input bit ls, input bit lv,
                        input logic [20:0] ld, input bit ll);
        bit          exp_fetch [2];
        logic [20:0] exp_word  [2];
        fetch_req  = fr;
        addr       = a;
        load_start = ls;
        load_valid = lv;
        load_data  = ld;
        load_last  = ll;
        for (int i = 0; i < 2; i++) begin
            exp_fetch[i] = !m_loading[i] && fr && !ls;
            exp_word[i]  = (int'(a) < m_cnt[i]) ? m_mem[i][a[7:0]] : DEF;
            if (ls) begin
                m_loading[i] = 1'b1;
                m_cnt[i]     = 0;
                m_ovf[i]     = 1'b0;
            end else if (m_loading[i] && lv) begin
                m_mem[i][m_cnt[i]] = ld;
                m_cnt[i]++;
                if (ll) begin
                    m_loading[i] = 1'b0;
                end else if (m_cnt[i] == depth_m[i]) begin
                    m_loading[i] = 1'b0;
                    m_ovf[i]     = 1'b1;
                end
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (exp_fetch[i]) q_push(i, exp_word[i]);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("busy", i, 32'(busy_w[i]), 32'(m_loading[i]));
            check("load_ready", i, 32'(lr_w[i]), 32'(m_loading[i]));
            check("load_ovf", i, 32'(ovf_w[i]), 32'(m_ovf[i]));
        end
    endtask

    task automatic idle();
        step(0, 16'h0, 0, 0, 21'h0, 0);
    endtask

    task automatic fetch(input logic [15:0] a);
        step(1, a, 0, 0, 21'h0, 0);
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 2; i++) begin
            check("rst_data", i, 32'(data_w[i]), 32'(DEF));
            check("rst_valid", i, 32'(dv_w[i]), 32'd0);
            check("rst_busy", i, 32'(busy_w[i]), 32'd0);
            check("rst_ready", i, 32'(lr_w[i]), 32'd0);
            check("rst_ovf", i, 32'(ovf_w[i]), 32'd0);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        fetch_req = 0; load_start = 0; load_valid = 0; load_last = 0;
        for (int i = 0; i < 2; i++) begin
            m_loading[i] = 1'b0;
            m_cnt[i]     = 0;
            m_ovf[i]     = 1'b0;
        end
        q0.delete();
        q1.delete();
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                logic [20:0] exp;
                if (dv_w[i]) begin
                    if (q_size(i) == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_valid inst%0d actual=%h required=no response t=%0t",
                                 i, data_w[i], $time);
                    end else begin
                        q_pop(i, exp);
                        check("fetch_data", i, 32'(data_w[i]), 32'(exp));
                    end
                end else if (q_size(i) != 0) begin
                    q_pop(i, exp);
                    vectors++;
                    miscompares++;
                    $display("FAIL missing_valid inst%0d actual=no response required=%h t=%0t",
                             i, exp, $time);
                end
            end
        end
    end

    logic [20:0] prog6 [6] = '{21'b011010000000000000010, 21'b010010000000000000000,
                               21'b111010000000000000001, 21'b111010000000000000010,
                               21'b111010000000000000011, 21'b100010000000000000000};

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_loading[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
        end
        #3;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Empty memory returns the default everywhere
        fetch(16'h0000);
        fetch(16'h0005);
        fetch(16'hFFFF);
        idle();

        // Six-word program (overflows the DEPTH-4 instance)
        step(0, 16'h0, 1, 0, 21'h0, 0);
        for (int k = 0; k < 6; k++) step(0, 16'h0, 0, 1, prog6[k], k == 5);
        for (int k = 0; k <= 6; k++) fetch(16'(k));
        idle();

        // Five words without load_last
        step(0, 16'h0, 1, 0, 21'h0, 0);
        for (int k = 0; k < 5; k++) step(0, 16'h0, 0, 1, 21'h1A000 + 21'(k), 0);
        fetch(16'd3);
        fetch(16'd4);
        idle();

        // Fetch held high across a two-word reload
        step(1, 16'd2, 1, 0, 21'h0, 0);
        step(1, 16'd2, 0, 1, 21'h0AAAA, 0);
        step(1, 16'd2, 0, 1, 21'h05555, 1);
        fetch(16'd0);
        fetch(16'd1);
        fetch(16'd2);
        idle();

        // Restart after three words; the colliding word is discarded
        step(0, 16'h0, 1, 0, 21'h0, 0);
        for (int k = 0; k < 3; k++) step(0, 16'h0, 0, 1, 21'h11110 + 21'(k), 0);
        step(0, 16'h0, 1, 1, 21'h1FFFF, 0);
        step(0, 16'h0, 0, 1, 21'h02222, 0);
        step(0, 16'h0, 0, 1, 21'h03333, 1);
        fetch(16'd0);
        fetch(16'd1);
        fetch(16'd2);
        idle();

        // Reset in the middle of a load discards the partial program
        step(0, 16'h0, 1, 0, 21'h0, 0);
        step(0, 16'h0, 0, 1, 21'h07777, 0);
        step(0, 16'h0, 0, 1, 21'h08888, 0);
        do_reset();
        fetch(16'd0);
        idle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit          ls = ($urandom_range(0, 39) == 0);
            bit          lv = ($urandom_range(0, 3) != 0);
            bit          ll = ($urandom_range(0, 7) == 0);
            bit          fr = ($urandom_range(0, 3) != 0);
            logic [15:0] a  = ($urandom_range(0, 4) != 0) ? 16'($urandom_range(0, 12))
                                                         : 16'($urandom);
            step(fr, a, ls, lv, 21'($urandom), ll);
        end
        idle();
        idle();
        check("drain", 0, 32'(q0.size()), 32'd0);
        check("drain", 1, 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
